// File: rtl/shader_sched_pkg.sv
// ----------------------------------------------------------------------------
// shader_sched_pkg
// Shared definitions for the shader stage scheduler:
//   - stage_e        : shader stage encoding (vertex, fragment, compute, ray)
//   - DEF_*          : default sizing for the scheduler and its sub-blocks
//   - wrap_inc()     : round-robin pointer advance helper
// ----------------------------------------------------------------------------
package shader_sched_pkg;

  typedef enum logic [1:0] {
    STAGE_VERTEX  = 2'd0,
    STAGE_FRAG    = 2'd1,
    STAGE_COMPUTE = 2'd2,
    STAGE_RAY     = 2'd3
  } stage_e;

  localparam int DEF_NUM_STAGES   = 32'sd4;
  localparam int DEF_NUM_SM       = 32'sd8;
  localparam int DEF_ID_WIDTH     = 32'sd32;
  localparam int DEF_SLOTS_PER_SM = 32'sd4;
  localparam int DEF_STARVE_LIMIT = 32'sd8;

  localparam int DEF_SM_IDX_W  = $clog2(DEF_NUM_SM);
  localparam int DEF_STG_IDX_W = $clog2(DEF_NUM_STAGES);
  localparam int DEF_CNT_W     = $clog2(DEF_SLOTS_PER_SM + 32'sd1);

  // Index one past idx, wrapping to zero at n.
  function automatic int wrap_inc(input int idx, input int n);
    if (idx + 32'sd1 >= n) begin
      return 32'sd0;
    end else begin
      return idx + 32'sd1;
    end
  endfunction

endpackage

// File: rtl/shader_stage_scheduler_rr_pick.sv
// ----------------------------------------------------------------------------
// rr_pick
// Round-robin first-set finder: returns the first asserted request at or after
// the start pointer, wrapping modulo N.
// Ports:
//   req   [N-1:0]      request vector
//   ptr   [IDX_W-1:0]  start position of the search
//   found              at least one request is asserted
//   idx   [IDX_W-1:0]  index of the selected request (0 when none found)
// ----------------------------------------------------------------------------
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
)(
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  logic hit_s;

  // Scan positions ptr, ptr+1, ... (mod N); the first hit wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    hit_s = 1'b0;
    for (int k = 0; k < N; k++) begin
      hit_s = !found && req[(int'(ptr) + k) % N];
      idx   = hit_s ? IDX_W'((int'(ptr) + k) % N) : idx;
      found = found | hit_s;
    end
  end

endmodule

// File: rtl/shader_stage_scheduler.sv
// ----------------------------------------------------------------------------
// shader_stage_scheduler
// Shares the SM array between the per-stage job queues. Each cycle one pending
// stage and one SM with a free slot are chosen (both round-robin) and the job
// is captured into a single registered dispatch towards the SM launch fabric.
// Per-SM occupancy is tracked with slot credits, reserved at load time and
// returned through the completion port.
//
// Optional build macro: SCHED_PRIO_EN
//   Adds stage_hi_prio and a two-level stage pick (high priority first) with a
//   starvation guard that forces a low-priority grant after STARVE_LIMIT
//   consecutive high-priority grants while low-priority work is pending.
//
// Ports:
//   clk, rstn          clock, asynchronous active-low reset
//   req_valid/job_id   per-stage pending job and its id (stage s at s*ID_WIDTH)
//   stage_hi_prio      per-stage high-priority flag (SCHED_PRIO_EN only)
//   req_ready          one-hot accept of the chosen stage (combinational)
//   disp_*             registered dispatch: valid/ready, stage, job id, SM
//   done_valid/done_sm completion of one job on an SM, returns a credit
//   sm_full            per-SM occupancy == SLOTS_PER_SM
//   credit_err         sticky: credit returned to an empty or unknown SM
// ----------------------------------------------------------------------------
module shader_stage_scheduler
  import shader_sched_pkg::*;
#(
  parameter int NUM_STAGES   = DEF_NUM_STAGES,
  parameter int NUM_SM       = DEF_NUM_SM,
  parameter int ID_WIDTH     = DEF_ID_WIDTH,
  parameter int SLOTS_PER_SM = DEF_SLOTS_PER_SM,
`ifdef SCHED_PRIO_EN
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT,
`endif
  parameter int SM_IDX_W     = $clog2(NUM_SM),
  parameter int STG_IDX_W    = $clog2(NUM_STAGES)
)(
  input  logic                           clk,
  input  logic                           rstn,
  input  logic [NUM_STAGES-1:0]          req_valid,
  input  logic [NUM_STAGES*ID_WIDTH-1:0] req_job_id,
`ifdef SCHED_PRIO_EN
  input  logic [NUM_STAGES-1:0]          stage_hi_prio,
`endif
  output logic [NUM_STAGES-1:0]          req_ready,
  output logic                           disp_valid,
  input  logic                           disp_ready,
  output logic [STG_IDX_W-1:0]           disp_stage,
  output logic [ID_WIDTH-1:0]            disp_job_id,
  output logic [SM_IDX_W-1:0]            disp_sm,
  input  logic                           done_valid,
  input  logic [SM_IDX_W-1:0]            done_sm,
  output logic [NUM_SM-1:0]              sm_full,
  output logic                           credit_err
);

  localparam int               CNT_W   = $clog2(SLOTS_PER_SM + 1);
  localparam logic [CNT_W-1:0] SLOTS_C = CNT_W'(SLOTS_PER_SM);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  logic [CNT_W-1:0]      occ_r      [NUM_SM];
  logic [CNT_W-1:0]      occ_next_s [NUM_SM];
  logic [NUM_SM-1:0]     sm_avail_s;
  logic [NUM_SM-1:0]     inc_s;
  logic [NUM_SM-1:0]     dec_s;
  logic                  done_hit_s;
  logic                  err_set_s;

  logic [STG_IDX_W-1:0]  stage_ptr_r;
  logic [SM_IDX_W-1:0]   sm_ptr_r;
  logic                  stage_found_s;
  logic [STG_IDX_W-1:0]  stage_idx_s;
  logic                  sm_found_s;
  logic [SM_IDX_W-1:0]   sm_idx_s;
  logic                  load_en_s;

  logic                  disp_valid_r;
  logic [STG_IDX_W-1:0]  disp_stage_r;
  logic [ID_WIDTH-1:0]   disp_job_id_r;
  logic [SM_IDX_W-1:0]   disp_sm_r;
  logic [NUM_SM-1:0]     sm_full_r;
  logic                  credit_err_r;

  // ---------------------------------------------------------------- stage pick
`ifdef SCHED_PRIO_EN
  localparam int                  STARVE_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [STARVE_W-1:0] STARVE_C = STARVE_W'(STARVE_LIMIT);

  logic [NUM_STAGES-1:0] hi_req_s;
  logic [NUM_STAGES-1:0] lo_req_s;
  logic                  hi_found_s;
  logic                  lo_found_s;
  logic [STG_IDX_W-1:0]  hi_idx_s;
  logic [STG_IDX_W-1:0]  lo_idx_s;
  logic                  use_lo_s;
  logic [STARVE_W-1:0]   starve_r;

  assign hi_req_s = req_valid & stage_hi_prio;
  assign lo_req_s = req_valid & ~stage_hi_prio;

  rr_pick #(.N(NUM_STAGES), .IDX_W(STG_IDX_W)) u_hi_pick (
    .req   (hi_req_s),
    .ptr   (stage_ptr_r),
    .found (hi_found_s),
    .idx   (hi_idx_s)
  );

  rr_pick #(.N(NUM_STAGES), .IDX_W(STG_IDX_W)) u_lo_pick (
    .req   (lo_req_s),
    .ptr   (stage_ptr_r),
    .found (lo_found_s),
    .idx   (lo_idx_s)
  );

  // Low priority wins when no high stage pends or the starve budget is spent.
  always_comb begin
    use_lo_s = 1'b0;
    if (lo_found_s && (!hi_found_s || (starve_r >= STARVE_C))) begin
      use_lo_s = 1'b1;
    end else begin
      use_lo_s = 1'b0;
    end
    stage_found_s = hi_found_s | lo_found_s;
    stage_idx_s   = use_lo_s ? lo_idx_s : hi_idx_s;
  end

  // Count consecutive high-priority grants made while low-priority work waits.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      starve_r <= '0;
    end else if (!lo_found_s) begin
      starve_r <= '0;
    end else if (load_en_s && use_lo_s) begin
      starve_r <= '0;
    end else if (load_en_s) begin
      starve_r <= starve_r + STARVE_W'(1);
    end else begin
      starve_r <= starve_r;
    end
  end
`else
  rr_pick #(.N(NUM_STAGES), .IDX_W(STG_IDX_W)) u_stage_pick (
    .req   (req_valid),
    .ptr   (stage_ptr_r),
    .found (stage_found_s),
    .idx   (stage_idx_s)
  );
`endif

  // ------------------------------------------------------------------- SM pick
  // Availability comes from registered occupancy only, so a slot freed this
  // cycle is first offered on the next one.
  always_comb begin
    sm_avail_s = '0;
    for (int i = 0; i < NUM_SM; i++) begin
      sm_avail_s[i] = (occ_r[i] != SLOTS_C);
    end
  end

  rr_pick #(.N(NUM_SM), .IDX_W(SM_IDX_W)) u_sm_pick (
    .req   (sm_avail_s),
    .ptr   (sm_ptr_r),
    .found (sm_found_s),
    .idx   (sm_idx_s)
  );

  assign load_en_s = (!disp_valid_r || disp_ready) && stage_found_s && sm_found_s;

  // One-hot accept towards the chosen stage front-end.
  always_comb begin
    req_ready = '0;
    if (load_en_s) begin
      req_ready[stage_idx_s] = 1'b1;
    end else begin
      req_ready = '0;
    end
  end

  // ------------------------------------------------------------------ credits
  // Next occupancy per SM; a return to an empty SM is dropped and flagged, a
  // simultaneous reserve and return on one SM cancel out.
  always_comb begin
    done_hit_s = done_valid && (int'(done_sm) < NUM_SM);
    err_set_s  = done_valid && !done_hit_s;
    inc_s      = '0;
    dec_s      = '0;
    for (int i = 0; i < NUM_SM; i++) begin
      inc_s[i]      = load_en_s && (sm_idx_s == SM_IDX_W'(i));
      dec_s[i]      = done_hit_s && (done_sm == SM_IDX_W'(i));
      occ_next_s[i] = occ_r[i];
      if (dec_s[i] && (occ_r[i] == '0)) begin
        err_set_s     = 1'b1;
        occ_next_s[i] = inc_s[i] ? (occ_r[i] + ONE_C) : occ_r[i];
      end else if (inc_s[i] && !dec_s[i]) begin
        occ_next_s[i] = occ_r[i] + ONE_C;
      end else if (dec_s[i] && !inc_s[i]) begin
        occ_next_s[i] = occ_r[i] - ONE_C;
      end else begin
        occ_next_s[i] = occ_r[i];
      end
    end
  end

  // Occupancy counters, full flags and the sticky credit error.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NUM_SM; i++) begin
        occ_r[i] <= '0;
      end
      sm_full_r    <= '0;
      credit_err_r <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_SM; i++) begin
        occ_r[i]     <= occ_next_s[i];
        sm_full_r[i] <= (occ_next_s[i] == SLOTS_C);
      end
      credit_err_r <= credit_err_r | err_set_s;
    end
  end

  // Round-robin pointers move past the winners only on a load.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stage_ptr_r <= '0;
      sm_ptr_r    <= '0;
    end else if (load_en_s) begin
      stage_ptr_r <= STG_IDX_W'(wrap_inc(int'(stage_idx_s), NUM_STAGES));
      sm_ptr_r    <= SM_IDX_W'(wrap_inc(int'(sm_idx_s), NUM_SM));
    end else begin
      stage_ptr_r <= stage_ptr_r;
      sm_ptr_r    <= sm_ptr_r;
    end
  end

  // Dispatch register: loads on a grant, drains on ready, holds while stalled.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      disp_valid_r  <= 1'b0;
      disp_stage_r  <= '0;
      disp_job_id_r <= '0;
      disp_sm_r     <= '0;
    end else if (load_en_s) begin
      disp_valid_r  <= 1'b1;
      disp_stage_r  <= stage_idx_s;
      disp_job_id_r <= req_job_id[int'(stage_idx_s)*ID_WIDTH +: ID_WIDTH];
      disp_sm_r     <= sm_idx_s;
    end else if (disp_ready) begin
      disp_valid_r  <= 1'b0;
    end else begin
      disp_valid_r  <= disp_valid_r;
    end
  end

  assign disp_valid  = disp_valid_r;
  assign disp_stage  = disp_stage_r;
  assign disp_job_id = disp_job_id_r;
  assign disp_sm     = disp_sm_r;
  assign sm_full     = sm_full_r;
  assign credit_err  = credit_err_r;

endmodule

// File: tb/tb_shader_stage_scheduler.sv
// ----------------------------------------------------------------------------
// tb_shader_stage_scheduler
// Self-checking bench for shader_stage_scheduler (default sizing). A
// behavioural model (occupancy array, integer pointers) predicts req_ready and
// the dispatch register every cycle; scenario tasks add fixed expectations.
// Build with SCHED_PRIO_EN defined to also exercise the priority pick.
// ----------------------------------------------------------------------------
module tb_shader_stage_scheduler;

  localparam int NS    = 4;
  localparam int NSM   = 8;
  localparam int IDW   = 32;
  localparam int SLOTS = 4;

  logic            clk = 1'b0;
  logic            rstn;
  logic [NS-1:0]   req_valid;
  logic [NS*IDW-1:0] req_job_id;
  logic [NS-1:0]   req_ready;
  logic            disp_valid;
  logic            disp_ready;
  logic [1:0]      disp_stage;
  logic [IDW-1:0]  disp_job_id;
  logic [2:0]      disp_sm;
  logic            done_valid;
  logic [2:0]      done_sm;
  logic [NSM-1:0]  sm_full;
  logic            credit_err;
`ifdef SCHED_PRIO_EN
  logic [NS-1:0]   stage_hi_prio;
`endif

  always #5 clk = ~clk;

  shader_stage_scheduler dut (
    .clk         (clk),
    .rstn        (rstn),
    .req_valid   (req_valid),
    .req_job_id  (req_job_id),
`ifdef SCHED_PRIO_EN
    .stage_hi_prio (stage_hi_prio),
`endif
    .req_ready   (req_ready),
    .disp_valid  (disp_valid),
    .disp_ready  (disp_ready),
    .disp_stage  (disp_stage),
    .disp_job_id (disp_job_id),
    .disp_sm     (disp_sm),
    .done_valid  (done_valid),
    .done_sm     (done_sm),
    .sm_full     (sm_full),
    .credit_err  (credit_err)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int          m_occ [NSM];
  int          m_sptr;
  int          m_mptr;
  bit          m_dv;
  int          m_stage;
  int          m_sm;
  logic [31:0] m_job;
  bit          m_err;
  int          m_starve;
  // Per-cycle prediction and observation
  bit          e_load;
  int          e_stage;
  int          e_sm;
  logic [NS-1:0] obs_ready;

  function automatic void model_reset();
    for (int i = 0; i < NSM; i++) m_occ[i] = 0;
    m_sptr = 0; m_mptr = 0; m_dv = 0; m_stage = 0; m_sm = 0;
    m_job = 32'h0; m_err = 0; m_starve = 0;
  endfunction

  function automatic void model_eval();
    logic [NS-1:0] pool;
    pool = req_valid;
`ifdef SCHED_PRIO_EN
    if ((req_valid & ~stage_hi_prio) != 4'b0000 &&
        ((req_valid & stage_hi_prio) == 4'b0000 || m_starve >= 8))
      pool = req_valid & ~stage_hi_prio;
    else
      pool = req_valid & stage_hi_prio;
`endif
    e_stage = -1;
    for (int k = 0; k < NS; k++)
      if (e_stage < 0 && pool[(m_sptr + k) % NS]) e_stage = (m_sptr + k) % NS;
    e_sm = -1;
    for (int k = 0; k < NSM; k++)
      if (e_sm < 0 && m_occ[(m_mptr + k) % NSM] < SLOTS) e_sm = (m_mptr + k) % NSM;
    e_load = (!m_dv || disp_ready) && e_stage >= 0 && e_sm >= 0;
  endfunction

  function automatic void model_commit();
    if (done_valid) begin
      if (int'(done_sm) >= NSM || m_occ[done_sm] == 0) m_err = 1;
      else m_occ[done_sm] = m_occ[done_sm] - 1;
    end
`ifdef SCHED_PRIO_EN
    if ((req_valid & ~stage_hi_prio) == 4'b0000) m_starve = 0;
    else if (e_load && !stage_hi_prio[e_stage]) m_starve = 0;
    else if (e_load) m_starve = m_starve + 1;
`endif
    if (e_load) begin
      m_dv    = 1;
      m_stage = e_stage;
      m_sm    = e_sm;
      m_job   = req_job_id[e_stage*IDW +: IDW];
      m_occ[e_sm] = m_occ[e_sm] + 1;
      m_sptr  = (e_stage + 1) % NS;
      m_mptr  = (e_sm + 1) % NSM;
    end else if (disp_ready) begin
      m_dv = 0;
    end
  endfunction

  // One clock: check req_ready mid-cycle, advance the model on the edge, then
  // check the registered outputs just after it.
  task automatic step();
    logic [NS-1:0]  exp_ready;
    logic [NSM-1:0] exp_full;
    @(negedge clk);
    model_eval();
    obs_ready = req_ready;
    exp_ready = e_load ? (4'b0001 << e_stage) : 4'b0000;
    checks++;
    if (req_ready !== exp_ready) begin
      failures++;
      $display("FAIL req_ready: got %b expected %b at %0t", req_ready, exp_ready, $time);
    end
    @(posedge clk);
    model_commit();
    #1;
    checks++;
    if (disp_valid !== m_dv) begin
      failures++;
      $display("FAIL disp_valid: got %b expected %b at %0t", disp_valid, m_dv, $time);
    end
    if (m_dv) begin
      checks++;
      if (disp_stage !== 2'(m_stage) || disp_sm !== 3'(m_sm) || disp_job_id !== m_job) begin
        failures++;
        $display("FAIL disp_payload: got stage=%0d sm=%0d id=%h expected stage=%0d sm=%0d id=%h at %0t",
                 disp_stage, disp_sm, disp_job_id, m_stage, m_sm, m_job, $time);
      end
    end
    for (int i = 0; i < NSM; i++) exp_full[i] = (m_occ[i] == SLOTS);
    checks++;
    if (sm_full !== exp_full || credit_err !== m_err) begin
      failures++;
      $display("FAIL credits: got sm_full=%b err=%b expected sm_full=%b err=%b at %0t",
               sm_full, credit_err, exp_full, m_err, $time);
    end
  endtask

  task automatic drive_idle();
    req_valid  = 4'b0000;
    disp_ready = 1'b0;
    done_valid = 1'b0;
    done_sm    = 3'd0;
    req_job_id = {$urandom, $urandom, $urandom, $urandom};
`ifdef SCHED_PRIO_EN
    stage_hi_prio = 4'b0000;
`endif
  endtask

  task automatic do_reset();
    drive_idle();
    rstn = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive_idle();
    rstn = 1'b1;
    #2 rstn = 1'b0;
    #1;
    checks++;
    if (disp_valid !== 1'b0 || disp_stage !== 2'd0 || disp_job_id !== 32'h0 || disp_sm !== 3'd0 ||
        sm_full !== 8'h00 || credit_err !== 1'b0 || req_ready !== 4'b0000) begin
      failures++;
      $display("FAIL reset_state: got dv=%b st=%0d id=%h sm=%0d full=%b err=%b rdy=%b expected all zero",
               disp_valid, disp_stage, disp_job_id, disp_sm, sm_full, credit_err, req_ready);
    end
    do_reset();
  endtask

  task automatic test_round_robin();
    int exp_st [5];
    int exp_sm [5];
    exp_st = '{0, 1, 2, 3, 0};
    exp_sm = '{0, 1, 2, 3, 4};
    do_reset();
    req_valid  = 4'b1111;
    disp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (disp_valid !== 1'b1 || disp_stage !== 2'(exp_st[i]) || disp_sm !== 3'(exp_sm[i])) begin
        failures++;
        $display("FAIL rr_order[%0d]: got dv=%b stage=%0d sm=%0d expected dv=1 stage=%0d sm=%0d",
                 i, disp_valid, disp_stage, disp_sm, exp_st[i], exp_sm[i]);
      end
    end
  endtask

  task automatic fill_all(output int grants);
    req_valid  = 4'b0001;
    disp_ready = 1'b1;
    grants = 0;
    for (int i = 0; i < 33; i++) begin
      step();
      if (obs_ready != 4'b0000) grants++;
    end
  endtask

  task automatic test_fill();
    int grants;
    do_reset();
    fill_all(grants);
    checks++;
    if (grants !== 32 || sm_full !== 8'hFF) begin
      failures++;
      $display("FAIL fill: got grants=%0d sm_full=%b expected grants=32 sm_full=11111111", grants, sm_full);
    end
    done_valid = 1'b1;
    done_sm    = 3'd5;
    step();
    checks++;
    if (obs_ready !== 4'b0000 || disp_valid !== 1'b0) begin
      failures++;
      $display("FAIL freed_same_cycle: got rdy=%b dv=%b expected rdy=0000 dv=0", obs_ready, disp_valid);
    end
    done_valid = 1'b0;
    step();
    checks++;
    if (disp_valid !== 1'b1 || disp_sm !== 3'd5) begin
      failures++;
      $display("FAIL refill_sm5: got dv=%b sm=%0d expected dv=1 sm=5", disp_valid, disp_sm);
    end
  endtask

  task automatic test_stall();
    logic [31:0] id2;
    do_reset();
    id2 = $urandom;
    req_job_id[2*IDW +: IDW] = id2;
    req_valid  = 4'b0100;
    disp_ready = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (disp_valid !== 1'b1 || disp_stage !== 2'd2 || disp_sm !== 3'd0 ||
          disp_job_id !== id2 || obs_ready !== 4'b0000) begin
        failures++;
        $display("FAIL stall_hold[%0d]: got dv=%b st=%0d sm=%0d id=%h rdy=%b expected dv=1 st=2 sm=0 id=%h rdy=0000",
                 i, disp_valid, disp_stage, disp_sm, disp_job_id, obs_ready, id2);
      end
    end
    disp_ready = 1'b1;
    req_valid  = 4'b0000;
    step();
    req_valid  = 4'b0100;
    step();
    checks++;
    if (disp_valid !== 1'b1 || disp_sm !== 3'd1) begin
      failures++;
      $display("FAIL after_stall: got dv=%b sm=%0d expected dv=1 sm=1", disp_valid, disp_sm);
    end
  endtask

  task automatic test_credit_collision();
    int grants;
    do_reset();
    fill_all(grants);
    done_valid = 1'b1;
    done_sm    = 3'd2;
    step();
    done_sm    = 3'd3;
    step();
    checks++;
    if (disp_valid !== 1'b1 || disp_sm !== 3'd2) begin
      failures++;
      $display("FAIL collision_skip_sm3: got dv=%b sm=%0d expected dv=1 sm=2", disp_valid, disp_sm);
    end
    done_valid = 1'b0;
    step();
    checks++;
    if (disp_valid !== 1'b1 || disp_sm !== 3'd3) begin
      failures++;
      $display("FAIL collision_next_sm3: got dv=%b sm=%0d expected dv=1 sm=3", disp_valid, disp_sm);
    end
    req_valid = 4'b0000;
    step();
    checks++;
    if (sm_full !== 8'hFF) begin
      failures++;
      $display("FAIL collision_full: got %b expected 11111111", sm_full);
    end
  endtask

  task automatic test_credit_err();
    do_reset();
    done_valid = 1'b1;
    done_sm    = 3'd6;
    step();
    checks++;
    if (credit_err !== 1'b1 || sm_full !== 8'h00) begin
      failures++;
      $display("FAIL credit_err_set: got err=%b full=%b expected err=1 full=00000000", credit_err, sm_full);
    end
    done_valid = 1'b0;
    repeat (3) step();
    req_valid  = 4'b0010;
    disp_ready = 1'b0;
    step();
    checks++;
    if (credit_err !== 1'b1 || disp_valid !== 1'b1) begin
      failures++;
      $display("FAIL credit_err_sticky: got err=%b dv=%b expected err=1 dv=1", credit_err, disp_valid);
    end
    #2 rstn = 1'b0;
    #1;
    checks++;
    if (credit_err !== 1'b0 || disp_valid !== 1'b0 || sm_full !== 8'h00) begin
      failures++;
      $display("FAIL mid_reset: got err=%b dv=%b full=%b expected 0 0 00000000", credit_err, disp_valid, sm_full);
    end
    do_reset();
  endtask

  task automatic test_random();
    int sm;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      req_valid  = 4'($urandom_range(0, 15));
      req_job_id = {$urandom, $urandom, $urandom, $urandom};
      disp_ready = ($urandom_range(0, 3) != 0);
      sm         = $urandom_range(0, NSM - 1);
      done_sm    = 3'(sm);
      done_valid = (m_occ[sm] > 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 31) == 0);
      step();
    end
  endtask

`ifdef SCHED_PRIO_EN
  task automatic test_prio();
    int exp_st [10];
    exp_st = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
    do_reset();
    stage_hi_prio = 4'b0001;
    req_valid     = 4'b1111;
    disp_ready    = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i == 8) done_valid = 1'b0;
      step();
      checks++;
      if (disp_valid !== 1'b1 || disp_stage !== 2'(exp_st[i])) begin
        failures++;
        $display("FAIL prio_order[%0d]: got dv=%b stage=%0d expected dv=1 stage=%0d",
                 i, disp_valid, disp_stage, exp_st[i]);
      end
    end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_round_robin();
    test_fill();
    test_stall();
    test_credit_collision();
    test_credit_err();
    test_random();
`ifdef SCHED_PRIO_EN
    test_prio();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
